// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product dot accumulator.
// State encoding plus product width/limit from the 4x3 multiplier.
package prod_acc_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ACCUM = 1'b0;
  localparam state_t HOLD  = 1'b1;

  localparam int PROD_W   = 7;
  localparam int PROD_MAX = 105;

endpackage

// File: rtl/prod_dot_accumulator.sv
// Sums groups of LEN multiplier products into one dot-product result.
// Ports: clk, rst (async high), in_valid/in_ready/in_prod (product
// stream), out_valid/out_ready/out_sum/out_ovf (registered result).
// Macro PROD_ACC_SAT_EN: clamp acc at 2^ACC_W-1 on overflow
// instead of wrapping; out_ovf reports overflow either way.
module prod_dot_accumulator
  import prod_acc_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             accept;
  logic [ACC_W:0]   next_sum;
  logic             ovf_nx;
  logic [ACC_W-1:0] acc_nx;

  // Pure state decode: no path from out_ready or in_valid.
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;

  assign next_sum = {1'b0, acc}
                  + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign ovf_nx   = ovf | next_sum[ACC_W];

`ifdef PROD_ACC_SAT_EN
  // Once overflowed, hold at full scale for the rest of the vector.
  assign acc_nx = ovf_nx ? '1 : next_sum[ACC_W-1:0];
`else
  assign acc_nx = next_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ACCUM): begin
          if (accept) begin
            acc <= acc_nx;
            ovf <= ovf_nx;
            if (cnt == LAST) begin
              out_sum   <= acc_nx;
              out_ovf   <= ovf_nx;
              out_valid <= 1'b1;
              state     <= HOLD;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        (state == HOLD): begin
          // acc is cleared at handshake, not at completion.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
